rast_tri_queue: RTL and testbench
=================================

// Module: rast_tri_queue
// PURPOSE
//  Triangle input queue directly upstream of rast. Accepts triangles from the vertex/setup side on a valid/ready
//  handshake, buffers up to DEPTH of them, and presents the head entry on rast's R10 inputs (tri_R10S, color_R10U,
//  validTri_R10H). Obeys rast backpressure on halt_RnnnnL. Lets upstream run ahead while rast iterates large bboxes.
// PARAMETERS
//  SIGFIG  = rast_params::SIGFIG  bits per coordinate/colour value
//  RADIX   = rast_params::RADIX   fraction bits (not used arithmetically; passed for consistency)
//  VERTS   = rast_params::VERTS   vertices per triangle (3)
//  AXIS    = rast_params::AXIS    axes per vertex (x,y,z)
//  COLORS  = rast_params::COLORS  colour channels
//  DEPTH   = 4                    queue entries; power of two, >=2
// PORTS
//  clk            in   1                          clock
//  rst            in   1                          synchronous reset, active-high
//  tri_in_S       in   SIGFIG x[VERTS][AXIS]      incoming triangle vertices, signed fixed point
//  color_in_U     in   SIGFIG x[COLORS]           incoming colour, unsigned
//  in_valid       in   1                          upstream triangle valid
//  in_ready       out  1                          queue can accept
//  tri_R10S       out  SIGFIG x[VERTS][AXIS]      head triangle to rast
//  color_R10U     out  SIGFIG x[COLORS]           head colour to rast
//  validTri_R10H  out  1                          head valid to rast
//  halt_RnnnnL    in   1                          from rast; 0 = rast stalled, do not advance
//  occupancy_U    out  $clog2(DEPTH)+1            entries held
//  cull_cnt_U     out  16                         triangles dropped by cull (0 when feature absent)
// BEHAVIOUR
//  - Reset: rd/wr ptr=0, occupancy_U=0, validTri_R10H=0, tri_R10S/color_R10U=0, cull_cnt_U=0, in_ready=1 next cycle.
//  - in_ready = (occupancy_U < DEPTH); depends on registered state only (no halt_RnnnnL->in_ready comb path).
//  - push = in_valid & in_ready & ~cull; pop = validTri_R10H & halt_RnnnnL (rast consumes on that edge).
//  - validTri_R10H = (occupancy_U != 0). Data outputs = head entry when valid, all-zero when empty.
//  - Latency: push at edge N into empty queue -> validTri_R10H=1 and data visible after edge N (1 cycle).
//  - While validTri_R10H=1 and halt_RnnnnL=0, outputs hold bit-stable (head never changes without pop).
//  - Simultaneous push+pop: occupancy unchanged, both ptrs advance; allowed at any non-full occupancy.
//  - Full: in_ready=0; a pop at edge N makes in_ready=1 after edge N. No same-cycle refill when full.
//  - Empty + push: no bypass; entry written, appears next cycle.
//  - Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH nor underflows.
//  - rst mid-operation discards all entries; in-flight in_valid on the reset cycle is dropped.
// CONFIGURATION
//  - Macro RAST_TRI_QUEUE_CULL_EN defined: at input compute signed area
//    A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), full 2*SIGFIG+2 precision, no truncation.
//    A <= 0 (back-facing or degenerate): cull=1; triangle is handshaken (in_ready honoured) but not stored;
//    cull_cnt_U increments, saturating at 16'hFFFF.
//  - Macro undefined: cull=0 always, every handshaken triangle stored; cull_cnt_U tied to 0.
// STRUCTURE
//  - rast_params package gains: TRIQ_DEPTH (=4), typedefs vert_t (signed [SIGFIG-1:0]),
//    tri_t ([VERTS][AXIS] vert_t), color_t ([COLORS] unsigned [SIGFIG-1:0]).
//  - Sub-module tri_area_cull (combinational, instantiated only under RAST_TRI_QUEUE_CULL_EN): tri_t in -> cull out.
//  - Storage: flop array of {tri_t, color_t} x DEPTH, gray-free binary ptrs (single clock domain).
// TESTING (SIGFIG=24, RADIX=10, DEPTH=4; 1.0 = 24'h000400)
//  1. Reset, then idle -> validTri_R10H=0, occupancy_U=0, in_ready=1, outputs 0.
//  2. Push tri (0,0),(4.0,0),(0,4.0), halt_RnnnnL=1 -> next cycle validTri_R10H=1 with exact data, popped that edge,
//     occupancy back to 0.
//  3. halt_RnnnnL=0, push 5 triangles back-to-back -> 4 accepted, in_ready=0 on the 5th; outputs hold triangle #1 stable.
//     Release halt -> drained in order #1..#4, one per cycle.
//  4. Occupancy=2, push and pop same cycle for 10 cycles -> occupancy stays 2, FIFO order preserved across ptr wrap.
//  5. Occupancy=3, assert rst for 1 cycle -> occupancy 0, validTri_R10H=0 next cycle; prior entries never emitted.
//  6. CULL_EN: push CW (0,0),(0,4.0),(4.0,0) and collinear (0,0),(1,1),(2,2) -> neither emitted, cull_cnt_U=2;
//     CCW triangle still passes. Without macro: all three emitted, cull_cnt_U=0.

Source files
------------

// File: rtl/rast_tri_queue_pkg.sv
// rast_tri_queue_pkg
//   Shared parameters and types for the rast triangle input queue.
//   Defines the fixed-point vertex, triangle and colour types used on both
//   the upstream (setup) side and the rast R10 side, plus one queue entry.
//   Optional feature macro used by the queue: RAST_TRI_QUEUE_CULL_EN.
package rast_tri_queue_pkg;

    localparam int unsigned SIGFIG     = 24;  // bits per coordinate/colour value
    localparam int unsigned RADIX      = 10;  // fraction bits
    localparam int unsigned VERTS      = 3;   // vertices per triangle
    localparam int unsigned AXIS       = 3;   // x, y, z
    localparam int unsigned COLORS     = 3;   // colour channels
    localparam int unsigned TRIQ_DEPTH = 4;   // default queue depth

    // Axis indices within a vertex
    localparam int unsigned AX_X = 0;
    localparam int unsigned AX_Y = 1;
    localparam int unsigned AX_Z = 2;

    // Signed area width: two SIGFIG+1 differences multiplied, then one
    // subtraction, so one guard bit above the product width.
    localparam int unsigned AREA_W = 2 * SIGFIG + 3;

    typedef logic signed [SIGFIG-1:0]           vert_t;
    typedef vert_t [VERTS-1:0][AXIS-1:0]        tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]      color_t;

    typedef struct packed {
        tri_t   tri_v;
        color_t color;
    } entry_t;

endpackage

// File: rtl/rast_tri_queue_if.sv
// rast_tri_queue_if
//   Handshake bundle around the triangle queue.
//   Upstream side : tri_in_S, color_in_U, in_valid (to queue), in_ready (from queue)
//   rast side     : tri_R10S, color_R10U, validTri_R10H (from queue),
//                   halt_RnnnnL (to queue, 0 = rast stalled)
//   modport slave  : the queue itself
//   modport master : the environment driving upstream data and rast halt
interface rast_tri_queue_if;
    import rast_tri_queue_pkg::*;

    tri_t   tri_in_S;
    color_t color_in_U;
    logic   in_valid;
    logic   in_ready;

    tri_t   tri_R10S;
    color_t color_R10U;
    logic   validTri_R10H;
    logic   halt_RnnnnL;

    modport slave (
        input  tri_in_S, color_in_U, in_valid, halt_RnnnnL,
        output in_ready, tri_R10S, color_R10U, validTri_R10H
    );

    modport master (
        output tri_in_S, color_in_U, in_valid, halt_RnnnnL,
        input  in_ready, tri_R10S, color_R10U, validTri_R10H
    );

endinterface

// File: rtl/rast_tri_queue_area_cull.sv
// tri_area_cull
//   Combinational back-face / degenerate test for an incoming triangle.
//   Computes A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) at full precision and
//   flags cull when A <= 0. Only used when RAST_TRI_QUEUE_CULL_EN is defined.
//   Ports:
//     tri_in : triangle vertices (z ignored)
//     cull   : 1 = triangle is back-facing or collinear
module tri_area_cull
    import rast_tri_queue_pkg::*;
(
    input  tri_t tri_in,
    output logic cull
);

    logic signed [SIGFIG:0]   x0, y0, x1, y1, x2, y2;
    logic signed [SIGFIG:0]   dx1, dy1, dx2, dy2;
    logic signed [AREA_W-1:0] area;
    logic                     unused_z;

    // Sign-extend by one bit so the differences cannot overflow.
    always_comb begin
        x0  = {tri_in[0][AX_X][SIGFIG-1], tri_in[0][AX_X]};
        y0  = {tri_in[0][AX_Y][SIGFIG-1], tri_in[0][AX_Y]};
        x1  = {tri_in[1][AX_X][SIGFIG-1], tri_in[1][AX_X]};
        y1  = {tri_in[1][AX_Y][SIGFIG-1], tri_in[1][AX_Y]};
        x2  = {tri_in[2][AX_X][SIGFIG-1], tri_in[2][AX_X]};
        y2  = {tri_in[2][AX_Y][SIGFIG-1], tri_in[2][AX_Y]};
        dx1 = x1 - x0;
        dy1 = y1 - y0;
        dx2 = x2 - x0;
        dy2 = y2 - y0;
        area = AREA_W'(dx1) * AREA_W'(dy2) - AREA_W'(dx2) * AREA_W'(dy1);
        cull = area[AREA_W-1] | (area == '0);
    end

    assign unused_z = ^{tri_in[0][AX_Z], tri_in[1][AX_Z], tri_in[2][AX_Z]};

endmodule

// File: rtl/rast_tri_queue.sv
// rast_tri_queue
//   Triangle FIFO directly upstream of rast. Accepts triangles on a
//   valid/ready handshake, holds up to DEPTH of them and presents the head
//   entry on rast's R10 inputs. The head advances only when rast is not
//   halted (halt_RnnnnL = 1) while validTri_R10H is high.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     q (slave)    : upstream data/valid/ready and rast R10 data/valid/halt
//     occupancy_U  : number of entries held
//     cull_cnt_U   : saturating count of culled triangles
//   Optional feature: define RAST_TRI_QUEUE_CULL_EN to drop back-facing and
//   degenerate triangles at the input (handshaken but not stored).
module rast_tri_queue
    import rast_tri_queue_pkg::*;
#(
    parameter int unsigned SIGFIG = rast_tri_queue_pkg::SIGFIG,
    parameter int unsigned RADIX  = rast_tri_queue_pkg::RADIX,
    parameter int unsigned VERTS  = rast_tri_queue_pkg::VERTS,
    parameter int unsigned AXIS   = rast_tri_queue_pkg::AXIS,
    parameter int unsigned COLORS = rast_tri_queue_pkg::COLORS,
    parameter int unsigned DEPTH  = rast_tri_queue_pkg::TRIQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    rast_tri_queue_if.slave          q,
    output logic [$clog2(DEPTH):0]   occupancy_U,
    output logic [15:0]              cull_cnt_U
);

    localparam int unsigned PW = $clog2(DEPTH);
    // Geometry is carried by the package types; these are kept for
    // interface compatibility with existing instantiations.
    localparam int unsigned unused_cfg = SIGFIG + RADIX + VERTS + AXIS + COLORS;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   occ;
    entry_t        head;
    logic          cull;
    logic          fire;
    logic          push;
    logic          pop;

    // Ready from registered occupancy only; no path from halt_RnnnnL.
    assign q.in_ready      = (occ != (PW+1)'(DEPTH));
    assign q.validTri_R10H = (occ != '0);
    assign fire            = q.in_valid & q.in_ready;
    assign push            = fire & ~cull;
    assign pop             = q.validTri_R10H & q.halt_RnnnnL;
    assign occupancy_U     = occ;

`ifdef RAST_TRI_QUEUE_CULL_EN
    logic [15:0] cull_cnt;

    tri_area_cull u_cull (
        .tri_in (q.tri_in_S),
        .cull   (cull)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cull_cnt <= '0;
        end else if (fire && cull && (cull_cnt != '1)) begin
            cull_cnt <= cull_cnt + 16'd1;
        end
    end

    assign cull_cnt_U = cull_cnt;
`else
    assign cull       = 1'b0;
    assign cull_cnt_U = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= '{tri_v: q.tri_in_S, color: q.color_in_U};
        end
    end

    always_comb begin
        head = '0;
        if (q.validTri_R10H) begin
            head = mem[rd_ptr];
        end
    end

    assign q.tri_R10S   = head.tri_v;
    assign q.color_R10U = head.color;

endmodule

// File: tb/tb_rast_tri_queue.sv
module tb_rast_tri_queue;
    import rast_tri_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef RAST_TRI_QUEUE_CULL_EN
    localparam bit CULL_ON = 1'b1;
`else
    localparam bit CULL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  occupancy_U;
    logic [15:0] cull_cnt_U;

    rast_tri_queue_if bus();

    rast_tri_queue #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .q           (bus),
        .occupancy_U (occupancy_U),
        .cull_cnt_U  (cull_cnt_U)
    );

    always #5 clk = ~clk;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Triangle with integer-unit coordinates (1.0 = 0x400); z and colour tagged.
    function automatic entry_t mk_tri(input int x0, input int y0, input int x1, input int y1,
                                      input int x2, input int y2, input int tag);
        entry_t e;
        e = '0;
        e.tri_v[0][AX_X] = vert_t'(x0 * 1024);
        e.tri_v[0][AX_Y] = vert_t'(y0 * 1024);
        e.tri_v[1][AX_X] = vert_t'(x1 * 1024);
        e.tri_v[1][AX_Y] = vert_t'(y1 * 1024);
        e.tri_v[2][AX_X] = vert_t'(x2 * 1024);
        e.tri_v[2][AX_Y] = vert_t'(y2 * 1024);
        for (int v = 0; v < 3; v++) e.tri_v[v][AX_Z] = vert_t'(tag);
        for (int c = 0; c < 3; c++) e.color[c] = SIGFIG'(tag + c);
        return e;
    endfunction

    // Counter-clockwise right triangle (area 16), translated by k.
    function automatic entry_t mk(input int k);
        return mk_tri(k, 0, k + 4, 0, k, 4, k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one triangle for one cycle; starts and ends at posedge+1.
    task automatic send(input entry_t e, input bit exp_rdy, input bit exp_store);
        bus.in_valid   = 1'b1;
        bus.tri_in_S   = e.tri_v;
        bus.color_in_U = e.color;
        if (exp_store) sb.push_back(e);
        @(negedge clk);
        chk("in_ready", 256'(bus.in_ready), 256'(exp_rdy));
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: every consumed head must match the oldest expected entry.
    initial begin
        entry_t exp_e;
        forever begin
            @(negedge clk);
            if (!rst && bus.validTri_R10H && bus.halt_RnnnnL) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got tri %0h expected no output", bus.tri_R10S);
                end else begin
                    exp_e = sb.pop_front();
                    if (bus.tri_R10S !== exp_e.tri_v || bus.color_R10U !== exp_e.color) begin
                        errors++;
                        $display("FAIL head_data: got %0h/%0h expected %0h/%0h",
                                 bus.tri_R10S, bus.color_R10U, exp_e.tri_v, exp_e.color);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tri_t held;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.halt_RnnnnL = 1'b1;
        bus.tri_in_S    = '0;
        bus.color_in_U  = '0;

        // 1: reset and idle
        tick(); tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_valid", 256'(bus.validTri_R10H), 256'(0));
        chk("rst_occ", 256'(occupancy_U), 256'(0));
        chk("rst_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_tri", 256'(bus.tri_R10S), 256'(0));
        chk("rst_color", 256'(bus.color_R10U), 256'(0));
        chk("rst_cullcnt", 256'(cull_cnt_U), 256'(0));
        tick();

        // 2: single triangle, one-cycle latency, consumed immediately
        send(mk(0), 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_valid", 256'(bus.validTri_R10H), 256'(1));
        chk("lat_occ", 256'(occupancy_U), 256'(1));
        tick();
        @(negedge clk);
        chk("t2_occ_after", 256'(occupancy_U), 256'(0));
        chk("t2_valid_after", 256'(bus.validTri_R10H), 256'(0));
        tick();

        // 3: fill under halt, fifth rejected, head holds, then drain
        bus.halt_RnnnnL = 1'b0;
        for (int i = 1; i <= 5; i++) send(mk(i), (i <= 4), (i <= 4));
        @(negedge clk);
        chk("full_occ", 256'(occupancy_U), 256'(4));
        chk("full_head", 256'(bus.tri_R10S), 256'(mk(1).tri_v));
        held = bus.tri_R10S;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("stall_hold", 256'(bus.tri_R10S), 256'(held));
        end
        tick();
        bus.halt_RnnnnL = 1'b1;
        @(negedge clk);
        chk("full_ready_before_pop", 256'(bus.in_ready), 256'(0));
        tick();
        @(negedge clk);
        chk("drain_occ3", 256'(occupancy_U), 256'(3));
        chk("ready_after_pop", 256'(bus.in_ready), 256'(1));
        tick(); tick(); tick();
        @(negedge clk);
        chk("drain_occ0", 256'(occupancy_U), 256'(0));
        chk("drain_sb", 256'(sb.size()), 256'(0));
        tick();

        // 4: steady push+pop at occupancy 2 across pointer wrap
        bus.halt_RnnnnL = 1'b0;
        send(mk(10), 1'b1, 1'b1);
        send(mk(11), 1'b1, 1'b1);
        bus.halt_RnnnnL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid   = 1'b1;
            bus.tri_in_S   = mk(20 + i).tri_v;
            bus.color_in_U = mk(20 + i).color;
            sb.push_back(mk(20 + i));
            @(negedge clk);
            chk("pp_occ", 256'(occupancy_U), 256'(2));
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("pp_occ_end", 256'(occupancy_U), 256'(0));
        chk("pp_sb", 256'(sb.size()), 256'(0));
        tick();

        // 5: reset with three entries held and a triangle in flight
        bus.halt_RnnnnL = 1'b0;
        for (int i = 30; i < 33; i++) send(mk(i), 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_occ", 256'(occupancy_U), 256'(3));
        tick();
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.tri_in_S   = mk(33).tri_v;
        bus.color_in_U = mk(33).color;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_occ", 256'(occupancy_U), 256'(0));
        chk("mid_rst_valid", 256'(bus.validTri_R10H), 256'(0));
        chk("mid_rst_ready", 256'(bus.in_ready), 256'(1));
        chk("mid_rst_tri", 256'(bus.tri_R10S), 256'(0));
        tick();
        bus.halt_RnnnnL = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        chk("post_rst_valid", 256'(bus.validTri_R10H), 256'(0));
        tick();

        // 6: clockwise and collinear triangles, then a counter-clockwise one
        send(mk_tri(0, 0, 0, 4, 4, 0, 40), 1'b1, !CULL_ON);
        send(mk_tri(0, 0, 1, 1, 2, 2, 41), 1'b1, !CULL_ON);
        send(mk(42), 1'b1, 1'b1);
        tick(); tick();
        @(negedge clk);
        chk("cull_cnt", 256'(cull_cnt_U), CULL_ON ? 256'(2) : 256'(0));
        chk("cull_occ", 256'(occupancy_U), 256'(0));
        chk("cull_sb", 256'(sb.size()), 256'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
